// File: rtl/set_reset_capture.sv
// set_reset_capture: time-stamps the rising and falling edges of an
// asynchronous pulse against a free-running counter. The result is held
// until the consumer acknowledges it. A rise that arrives while a result
// is still held raises a sticky overrun flag.
module set_reset_capture #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_compare,
  input  logic             in,
  input  logic             ena,
  input  logic             ack,
  output logic [WIDTH-1:0] set_data,
  output logic [WIDTH-1:0] reset_data,
  output logic [WIDTH-1:0] pulse_width,
  output logic             valid,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FALL = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic s1;
  logic s2;
  logic d;
  logic rise;
  logic fall;

  logic load_set;
  logic load_reset;
  logic valid_nxt;
  logic overrun_nxt;

  // Two-flop synchronizer plus a delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
      d  <= s2;
    end
  end

  // Single-cycle edge strobes on the synchronized signal.
  assign rise = s2 & ~d;
  assign fall = ~s2 & d;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and register-load decisions.
  always_comb begin
    state_nxt   = state;
    load_set    = 1'b0;
    load_reset  = 1'b0;
    valid_nxt   = valid;
    overrun_nxt = overrun;

    case (state)
      IDLE: begin
        // A fall seen here belongs to a pulse whose rise was not captured.
        if (rise && ena) begin
          load_set  = 1'b1;
          state_nxt = WAIT_FALL;
        end
      end

      WAIT_FALL: begin
        // Dropping ena abandons the measurement, even against a fall.
        if (!ena) begin
          state_nxt = IDLE;
        end else if (fall) begin
          load_reset = 1'b1;
          valid_nxt  = 1'b1;
          state_nxt  = DONE;
        end
      end

      DONE: begin
        if (ack) begin
          valid_nxt   = 1'b0;
          overrun_nxt = 1'b0;
          // A rise coincident with ack starts a new capture, no overrun.
          if (rise && ena) begin
            load_set  = 1'b1;
            state_nxt = WAIT_FALL;
          end else begin
            state_nxt = IDLE;
          end
        end else if (rise) begin
          // The held result is kept; this rise is dropped.
          overrun_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture registers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_data    <= '0;
      reset_data  <= '0;
      pulse_width <= '0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load_set) begin
        set_data <= data_compare;
      end
      if (load_reset) begin
        reset_data  <= data_compare;
        // Modulo subtraction keeps the width correct across counter wrap.
        pulse_width <= WIDTH'(data_compare - set_data);
      end
      valid   <= valid_nxt;
      overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_set_reset_capture.sv
// Directed bench for set_reset_capture with an expected-result scoreboard.
module tb_set_reset_capture;

  localparam int unsigned W = 24;

  typedef struct {
    logic [W-1:0] set_v;
    logic [W-1:0] reset_v;
    logic [W-1:0] width_v;
  } result_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_compare;
  logic         in;
  logic         ena;
  logic         ack;
  logic [W-1:0] set_data;
  logic [W-1:0] reset_data;
  logic [W-1:0] pulse_width;
  logic         valid;
  logic         overrun;

  int checks;
  int errors;
  result_t sb[$];

  set_reset_capture #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_compare (data_compare),
    .in           (in),
    .ena          (ena),
    .ack          (ack),
    .set_data     (set_data),
    .reset_data   (reset_data),
    .pulse_width  (pulse_width),
    .valid        (valid),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] s, input logic [W-1:0] r);
    result_t e;
    e.set_v   = s;
    e.reset_v = r;
    e.width_v = W'(r - s);
    sb.push_back(e);
  endtask

  // Rise with counter value rv, hold, fall with counter value fv, hold.
  task automatic pulse(input logic [W-1:0] rv, input logic [W-1:0] fv, input int hold);
    data_compare = rv;
    in = 1'b1;
    repeat (hold) tick();
    data_compare = fv;
    in = 1'b0;
    repeat (hold) tick();
  endtask

  // Bounded wait for valid, then compare against the scoreboard head.
  task automatic expect_result(input string tag);
    int n;
    result_t e;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, W'(valid), W'(1));
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_set"},   set_data,    e.set_v);
      check({tag, "_reset"}, reset_data,  e.reset_v);
      check({tag, "_width"}, pulse_width, e.width_v);
    end
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_valid_clr"},   W'(valid),   W'(0));
    check({tag, "_overrun_clr"}, W'(overrun), W'(0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    data_compare = '0;
    in = 1'b0;
    ena = 1'b0;
    ack = 1'b0;
    repeat (3) tick();
    check("rst_set",     set_data,    W'(0));
    check("rst_reset",   reset_data,  W'(0));
    check("rst_width",   pulse_width, W'(0));
    check("rst_valid",   W'(valid),   W'(0));
    check("rst_overrun", W'(overrun), W'(0));
    rst = 1'b0;
    ena = 1'b1;
    tick();

    // Basic capture.
    push(W'(100), W'(350));
    pulse(W'(100), W'(350), 4);
    expect_result("basic");
    do_ack("basic");

    // Latency: counter k is present before edge k+1; capture at edge 3.
    data_compare = W'(0);
    in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      data_compare = W'(k);
    end
    check("lat_set", set_data, W'(2));
    push(W'(2), W'(50));
    data_compare = W'(50);
    in = 1'b0;
    repeat (4) tick();
    expect_result("lat");
    do_ack("lat");

    // Counter wrap between rise and fall.
    push(24'hFFFFF0, 24'h000010);
    pulse(24'hFFFFF0, 24'h000010, 4);
    expect_result("wrap");
    check("wrap_width_lit", pulse_width, 24'h000020);
    do_ack("wrap");

    // Overrun: second pulse while unacknowledged.
    push(W'(1000), W'(1300));
    pulse(W'(1000), W'(1300), 4);
    expect_result("ovr_first");
    pulse(W'(2000), W'(2500), 4);
    check("ovr_flag",  W'(overrun), W'(1));
    check("ovr_valid", W'(valid),   W'(1));
    check("ovr_set",   set_data,    W'(1000));
    check("ovr_reset", reset_data,  W'(1300));
    check("ovr_width", pulse_width, W'(300));
    do_ack("ovr");

    // Ack coincident with a rise starts a new capture.
    push(W'(3000), W'(3400));
    pulse(W'(3000), W'(3400), 4);
    expect_result("ackr_first");
    data_compare = W'(4000);
    in = 1'b1;
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ackr_set",     set_data,    W'(4000));
    check("ackr_valid",   W'(valid),   W'(0));
    check("ackr_overrun", W'(overrun), W'(0));

    // ena dropped in WAIT_FALL: back to IDLE, later fall ignored.
    ena = 1'b0;
    tick();
    data_compare = W'(4500);
    in = 1'b0;
    ena = 1'b1;
    repeat (6) tick();
    check("enadrop_valid", W'(valid),  W'(0));
    check("enadrop_set",   set_data,   W'(4000));
    check("enadrop_reset", reset_data, W'(3400));
    check("enadrop_width", pulse_width, W'(400));

    // ena low in IDLE: a whole pulse is ignored.
    ena = 1'b0;
    pulse(W'(6000), W'(6100), 4);
    check("ena0_valid", W'(valid), W'(0));
    check("ena0_set",   set_data,  W'(4000));
    ena = 1'b1;

    // Glitch narrower than a clock period never reaches the synchronizer.
    data_compare = W'(7000);
    in = 1'b1;
    #2;
    in = 1'b0;
    repeat (6) tick();
    check("glitch_valid", W'(valid), W'(0));
    check("glitch_set",   set_data,  W'(4000));

    // Reset mid-WAIT_FALL clears outputs immediately; following fall ignored.
    data_compare = W'(5000);
    in = 1'b1;
    repeat (4) tick();
    check("midrst_pre_set", set_data, W'(5000));
    rst = 1'b1;
    #1;
    check("midrst_set",   set_data,    W'(0));
    check("midrst_reset", reset_data,  W'(0));
    check("midrst_width", pulse_width, W'(0));
    check("midrst_valid", W'(valid),   W'(0));
    in = 1'b0;
    data_compare = W'(5200);
    #2;
    rst = 1'b0;
    repeat (6) tick();
    check("midrst_after_valid", W'(valid),  W'(0));
    check("midrst_after_reset", reset_data, W'(0));

    // in held high through reset release: the synchronizer fill is a rise.
    data_compare = W'(777);
    in = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    push(W'(777), W'(800));
    repeat (4) tick();
    data_compare = W'(800);
    in = 1'b0;
    repeat (4) tick();
    expect_result("relhigh");
    do_ack("relhigh");

    check("sb_drained", W'(sb.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
